drl2_resp: RTL

- Directory-side responder for the single aggregated L2 channel that carries merged per-core L2 traffic.
- Accepts l2todr_req and returns one drtol2_snack per request, after a programmable latency, with nid and l2id echoed so the upstream arbiter can route the snack by nid[4:3].
- Accepts l2todr_disp and returns one drtol2_dack per displacement.
- Sinks snoop_ack and pfreq traffic.
- Used as a directory stand-in for bring-up and arbiter verification.

---
 rtl/drl2_resp.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/drl2_resp.sv
// drl2_resp: directory stand-in answering L2 requests with snacks and displacements with dacks
// Ports: clk/reset (sync, active-low); l2todr_req -> drtol2_snack after LAT cycles via a DEPTH-entry FIFO;
// l2todr_disp -> drtol2_dack (single entry); snoop_ack and pfreq are sunk; req/disp/sack counters wrap at 16 bits.
package drl2_pkg;
  typedef struct packed {
    logic [4:0]  nid;
    logic [5:0]  l2id;
    logic [2:0]  cmd;
    logic [38:0] paddr;
  } I_l2todr_req_type;
  typedef struct packed {
    logic [4:0]  nid;
    logic [5:0]  l2id;
    logic [5:0]  drid;
    logic [2:0]  snack;
    logic [38:0] paddr;
  } I_drtol2_snack_type;
  typedef struct packed {
    logic [4:0]  nid;
    logic [5:0]  l2id;
    logic [5:0]  drid;
    logic [15:0] mask;
    logic [1:0]  dcmd;
    logic [38:0] paddr;
  } I_l2todr_disp_type;
  typedef struct packed {
    logic [4:0] nid;
    logic [5:0] l2id;
    logic [5:0] drid;
  } I_drtol2_dack_type;
  typedef struct packed {
    logic [5:0] l2id;
    logic [1:0] directory_id;
  } I_drsnoop_ack_type;
  typedef struct packed {
    logic [4:0]  nid;
    logic [38:0] paddr;
  } I_l2todr_pfreq_type;
endpackage

module drl2_resp
  import drl2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic l2todr_req_valid,
  output logic l2todr_req_retry,
  input  logic [$bits(I_l2todr_req_type)-1:0] l2todr_req,
  output logic drtol2_snack_valid,
  input  logic drtol2_snack_retry,
  output logic [$bits(I_drtol2_snack_type)-1:0] drtol2_snack,
  input  logic l2todr_disp_valid,
  output logic l2todr_disp_retry,
  input  logic [$bits(I_l2todr_disp_type)-1:0] l2todr_disp,
  output logic drtol2_dack_valid,
  input  logic drtol2_dack_retry,
  output logic [$bits(I_drtol2_dack_type)-1:0] drtol2_dack,
  input  logic l2todr_snoop_ack_valid,
  output logic l2todr_snoop_ack_retry,
  input  logic [$bits(I_drsnoop_ack_type)-1:0] l2todr_snoop_ack,
  input  logic l2todr_pfreq_valid,
  output logic l2todr_pfreq_retry,
  input  logic [$bits(I_l2todr_pfreq_type)-1:0] l2todr_pfreq,
  output logic [15:0] req_cnt,
  output logic [15:0] disp_cnt,
  output logic [15:0] sack_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  I_l2todr_req_type mem [DEPTH];
  I_l2todr_req_type head;
  I_l2todr_disp_type disp;
  I_drtol2_snack_type snack_q;
  I_drtol2_dack_type dack_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ, occ_n;
  logic push, pop, snack_xfer, disp_xfer, dack_xfer, unused;
  assign head = mem[rd_ptr];
  assign disp = l2todr_disp;
  assign push = l2todr_req_valid & ~l2todr_req_retry;
  assign pop = (state == WAIT) && (cnt == 4'(LAT));
  assign snack_xfer = drtol2_snack_valid & ~drtol2_snack_retry;
  assign disp_xfer = l2todr_disp_valid & ~l2todr_disp_retry;
  assign dack_xfer = drtol2_dack_valid & ~drtol2_dack_retry;
  assign occ_n = occ + (AW+1)'(push) - (AW+1)'(pop);
  assign drtol2_snack_valid = (state == SEND);
  assign drtol2_snack = snack_q;
  assign drtol2_dack = dack_q;
  assign l2todr_disp_retry = drtol2_dack_valid;
  assign l2todr_snoop_ack_retry = 1'b0;
  assign l2todr_pfreq_retry = 1'b0;
  assign unused = ^{l2todr_snoop_ack, l2todr_pfreq, l2todr_pfreq_valid, head.cmd, disp.drid, disp.mask, disp.dcmd, disp.paddr};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    unique case (state)
      IDLE: begin
        state_n = occ != '0 ? WAIT : IDLE;
        cnt_n = 4'd1;
      end
      WAIT: begin
        state_n = pop ? SEND : WAIT;
        cnt_n = pop ? cnt : cnt + 4'd1;
      end
      SEND: begin
        state_n = !snack_xfer ? SEND : occ != '0 ? WAIT : IDLE;
        cnt_n = 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= l2todr_req;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      l2todr_req_retry <= 1'b0;
      snack_q <= '0;
      drtol2_dack_valid <= 1'b0;
      dack_q <= '0;
      req_cnt <= '0;
      disp_cnt <= '0;
      sack_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      occ <= occ_n;
      l2todr_req_retry <= occ_n == (AW+1)'(DEPTH);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        snack_q <= '{nid: head.nid, l2id: head.l2id, paddr: head.paddr, default: '0};
      end
      if (disp_xfer) begin
        drtol2_dack_valid <= 1'b1;
        dack_q <= '{nid: disp.nid, l2id: disp.l2id, default: '0};
      end else if (dack_xfer) drtol2_dack_valid <= 1'b0;
      if (push) req_cnt <= req_cnt + 16'd1;
      if (disp_xfer) disp_cnt <= disp_cnt + 16'd1;
      if (l2todr_snoop_ack_valid) sack_cnt <= sack_cnt + 16'd1;
    end
  end
endmodule
